// File: rtl/data_ram_lines.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | data_ram_lines: banked 1R1W data RAM, CPU word port + line port, arbiter.  |
// | Option macro: DATA_RAM_BYPASS_EN (same-cycle write-to-read forwarding).    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module data_ram_lines #(
  parameter int DWIDTH    = 11,
  parameter int NBANK_LOG = 2
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              cpu_ren,
  input  logic [DWIDTH-1:0]                 cpu_radr,
  output logic [31:0]                       cpu_rdata,
  output logic                              cpu_rvalid,
  input  logic [3:0]                        cpu_wen,
  input  logic [DWIDTH-1:0]                 cpu_wadr,
  input  logic [31:0]                       cpu_wdata,
  output logic                              cpu_stall,
  input  logic                              line_req,
  input  logic                              line_we,
  input  logic [DWIDTH-NBANK_LOG-1:0]       line_adr,
  input  logic [32*(2**NBANK_LOG)-1:0]      line_wdata,
  output logic                              line_ack,
  output logic [32*(2**NBANK_LOG)-1:0]      line_rdata,
  output logic                              line_rvalid
);

  localparam int NBANK  = 2**NBANK_LOG;
  localparam int LINE_W = 32*NBANK;
  localparam int ROW_W  = DWIDTH-NBANK_LOG;
  localparam int DEPTH  = 2**ROW_W;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_LINE     = 2'd1,
    S_CPU_TURN = 2'd2
  } state_t;

  state_t               r_state;
  logic                 w_cpu_req;
  logic                 w_grant;
  logic                 w_cpu_wr;
  logic                 w_cpu_rd;
  logic                 w_line_wr;
  logic [ROW_W-1:0]     w_rd_row;
  logic [NBANK_LOG-1:0] r_sel;
  logic [31:0]          r_cpu_hold;
  logic [LINE_W-1:0]    r_line_hold;
  logic [LINE_W-1:0]    w_q;

  assign w_cpu_req = cpu_ren | (|cpu_wen);

  // After one line grant with the CPU waiting, the next cycle belongs to the CPU.
  always_comb begin
    w_grant = 1'b0;
    if (rst_n) begin
      case (r_state)
        S_LINE:  w_grant = line_req & ~w_cpu_req;
        default: w_grant = line_req;
      endcase
    end
  end

  assign line_ack  = w_grant;
  assign cpu_stall = w_cpu_req & w_grant;
  assign w_cpu_wr  = (|cpu_wen) & ~w_grant & rst_n;
  assign w_cpu_rd  = cpu_ren & ~w_grant;
  assign w_line_wr = w_grant & line_we;
  assign w_rd_row  = w_grant ? line_adr : cpu_radr[DWIDTH-1:NBANK_LOG];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      cpu_rvalid  <= 1'b0;
      line_rvalid <= 1'b0;
      r_sel       <= '0;
      r_cpu_hold  <= '0;
      r_line_hold <= '0;
    end else begin
      case (r_state)
        S_LINE: begin
          if (!line_req)      r_state <= S_IDLE;
          else if (w_cpu_req) r_state <= S_CPU_TURN;
          else                r_state <= S_LINE;
        end
        default: r_state <= line_req ? S_LINE : S_IDLE;
      endcase
      cpu_rvalid  <= w_cpu_rd;
      line_rvalid <= w_grant & ~line_we;
      if (w_cpu_rd) r_sel <= cpu_radr[NBANK_LOG-1:0];
      r_cpu_hold  <= cpu_rdata;
      r_line_hold <= line_rdata;
    end
  end

  for (genvar b = 0; b < NBANK; b++) begin : g_bank
    logic [31:0]      r_mem [DEPTH];
    logic [31:0]      r_q;
    logic             w_cpu_hit;
    logic [ROW_W-1:0] w_wr_row;
    logic [31:0]      w_wr_data;
    logic [3:0]       w_wr_be;
    logic [31:0]      w_rd_old;
    logic [31:0]      w_rd_new;

    assign w_cpu_hit = w_cpu_wr & (cpu_wadr[NBANK_LOG-1:0] == NBANK_LOG'(b));
    assign w_wr_row  = w_line_wr ? line_adr : cpu_wadr[DWIDTH-1:NBANK_LOG];
    assign w_wr_data = w_line_wr ? line_wdata[b*32 +: 32] : cpu_wdata;
    assign w_wr_be   = w_line_wr ? 4'hF : (w_cpu_hit ? cpu_wen : 4'h0);
    assign w_rd_old  = r_mem[w_rd_row];

`ifdef DATA_RAM_BYPASS_EN
    always_comb begin
      w_rd_new = w_rd_old;
      if (w_cpu_hit && (w_wr_row == w_rd_row)) begin
        for (int i = 0; i < 4; i++) begin
          if (cpu_wen[i]) w_rd_new[8*i +: 8] = cpu_wdata[8*i +: 8];
        end
      end
    end
`else
    assign w_rd_new = w_rd_old;
`endif

    // Read register loads every cycle; only cycles flagged by rvalid are consumed.
    always_ff @(posedge clk) begin
      r_q <= w_rd_new;
      for (int i = 0; i < 4; i++) begin
        if (w_wr_be[i]) r_mem[w_wr_row][8*i +: 8] <= w_wr_data[8*i +: 8];
      end
    end

    assign w_q[b*32 +: 32] = r_q;
  end

  assign cpu_rdata  = cpu_rvalid  ? w_q[{r_sel, 5'b00000} +: 32] : r_cpu_hold;
  assign line_rdata = line_rvalid ? w_q : r_line_hold;

endmodule
`default_nettype wire

// File: tb/tb_data_ram_lines.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_data_ram_lines: scoreboard bench for data_ram_lines.                    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_data_ram_lines;
  localparam int DWIDTH    = 11;
  localparam int NBANK_LOG = 2;
  localparam int LINE_W    = 128;

  logic                        clk = 1'b0;
  logic                        rst_n;
  logic                        cpu_ren;
  logic [DWIDTH-1:0]           cpu_radr;
  logic [31:0]                 cpu_rdata;
  logic                        cpu_rvalid;
  logic [3:0]                  cpu_wen;
  logic [DWIDTH-1:0]           cpu_wadr;
  logic [31:0]                 cpu_wdata;
  logic                        cpu_stall;
  logic                        line_req;
  logic                        line_we;
  logic [DWIDTH-NBANK_LOG-1:0] line_adr;
  logic [LINE_W-1:0]           line_wdata;
  logic                        line_ack;
  logic [LINE_W-1:0]           line_rdata;
  logic                        line_rvalid;

  data_ram_lines #(.DWIDTH(DWIDTH), .NBANK_LOG(NBANK_LOG)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_ren(cpu_ren), .cpu_radr(cpu_radr), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
    .cpu_wen(cpu_wen), .cpu_wadr(cpu_wadr), .cpu_wdata(cpu_wdata), .cpu_stall(cpu_stall),
    .line_req(line_req), .line_we(line_we), .line_adr(line_adr), .line_wdata(line_wdata),
    .line_ack(line_ack), .line_rdata(line_rdata), .line_rvalid(line_rvalid)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  logic [31:0]       q_cpu  [$];
  logic [LINE_W-1:0] q_line [$];
  localparam logic [LINE_W-1:0] LINE0123 = {32'h3, 32'h2, 32'h1, 32'h0};

  task automatic chk(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT flags valid read data.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (cpu_rvalid) begin
        if (q_cpu.size() == 0) chk("cpu_rvalid_unexpected", 1, 0);
        else chk("cpu_rdata", {96'h0, cpu_rdata}, {96'h0, q_cpu.pop_front()});
      end
      if (line_rvalid) begin
        if (q_line.size() == 0) chk("line_rvalid_unexpected", 1, 0);
        else chk("line_rdata", line_rdata, q_line.pop_front());
      end
    end
  end

  task automatic idle();
    cpu_ren = 0; cpu_radr = '0; cpu_wen = 4'h0; cpu_wadr = '0; cpu_wdata = '0;
    line_req = 0; line_we = 0; line_adr = '0; line_wdata = '0;
  endtask

  task automatic cyc();
    @(posedge clk); #1;
    idle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] exp_ack;
    exp_ack = 4'b0101;
    idle();
    rst_n = 0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_cpu_rdata", {96'h0, cpu_rdata}, 0);
    chk("rst_cpu_rvalid", {127'h0, cpu_rvalid}, 0);
    chk("rst_cpu_stall", {127'h0, cpu_stall}, 0);
    chk("rst_line_ack", {127'h0, line_ack}, 0);
    chk("rst_line_rdata", line_rdata, 0);
    chk("rst_line_rvalid", {127'h0, line_rvalid}, 0);
    @(negedge clk) rst_n = 1;

    cyc(); cpu_wen = 4'hF; cpu_wadr = 5; cpu_wdata = 32'hDEADBEEF;
    cyc(); cpu_ren = 1; cpu_radr = 5; q_cpu.push_back(32'hDEADBEEF);

    cyc(); line_req = 1; line_we = 1; line_adr = 1; line_wdata = LINE0123;
    #1; chk("line_wr_ack", {127'h0, line_ack}, 1);
    chk("line_wr_no_stall", {127'h0, cpu_stall}, 0);
    for (int i = 4; i < 8; i++) begin
      cyc(); cpu_ren = 1; cpu_radr = DWIDTH'(i); q_cpu.push_back(32'(i - 4));
    end

    cyc(); cpu_wen = 4'hF; cpu_wadr = 9; cpu_wdata = 32'h11223344;
    cyc(); cpu_wen = 4'b0010; cpu_wadr = 9; cpu_wdata = 32'h0000AB00;
    cyc(); cpu_ren = 1; cpu_radr = 9; q_cpu.push_back(32'h1122AB44);

    cyc(); line_req = 1; line_adr = 1; q_line.push_back(LINE0123);
    #1; chk("line_rd_ack", {127'h0, line_ack}, 1);
    cyc();
    cyc();

    // Line request held for four cycles against continuous CPU reads.
    for (int k = 0; k < 4; k++) begin
      cyc(); line_req = 1; line_adr = 1; cpu_ren = 1; cpu_radr = 9;
      #1; chk($sformatf("arb_ack_%0d", k), {127'h0, line_ack}, {127'h0, exp_ack[k]});
      chk($sformatf("arb_stall_%0d", k), {127'h0, cpu_stall}, {127'h0, exp_ack[k]});
      if (exp_ack[k]) q_line.push_back(LINE0123);
      else q_cpu.push_back(32'h1122AB44);
    end
    cyc();
    cyc();

    cyc(); cpu_wen = 4'hF; cpu_wadr = 12; cpu_wdata = 32'h0;
    cyc(); cpu_wen = 4'hF; cpu_wadr = 12; cpu_wdata = 32'h55; cpu_ren = 1; cpu_radr = 12;
`ifdef DATA_RAM_BYPASS_EN
    q_cpu.push_back(32'h55);
`else
    q_cpu.push_back(32'h0);
`endif
    cyc(); cpu_ren = 1; cpu_radr = 12; q_cpu.push_back(32'h55);
    cyc();
    cyc();

    // Reset lands before the edge that would raise line_rvalid.
    cyc(); line_req = 1; line_adr = 1;
    #1; chk("pre_rst_ack", {127'h0, line_ack}, 1);
    @(negedge clk); rst_n = 0; idle();
    @(posedge clk); #1;
    chk("rst_kill_rvalid", {127'h0, line_rvalid}, 0);
    chk("rst_line_rdata_clear", line_rdata, 0);
    @(negedge clk) rst_n = 1;
    cyc(); line_req = 1; line_adr = 1; cpu_ren = 1; cpu_radr = 9;
    #1; chk("post_rst_ack_idle", {127'h0, line_ack}, 1);
    chk("post_rst_stall", {127'h0, cpu_stall}, 1);
    q_line.push_back(LINE0123);
    cyc();
    cyc();
    cyc();

    chk("cpu_queue_empty", 128'(q_cpu.size()), 0);
    chk("line_queue_empty", 128'(q_line.size()), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
`default_nettype wire
